// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch sequencer bundle: launch control, decoder feedback, pc and status
interface fetch_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             stall;
    logic             halt_req;
    logic             branch_en;
    logic             branch_abs;
    logic [OFF_W-1:0] branch_off;
    logic [PC_W-1:0]  jump_target;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, start_addr, stall, halt_req,
        input  branch_en, branch_abs, branch_off, jump_target,
        output pc, running, done, instr_count
    );

    modport slave (
        output start, start_addr, stall, halt_req,
        output branch_en, branch_abs, branch_off, jump_target,
        input  pc, running, done, instr_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - program counter and fetch sequencer with IDLE/RUN/HALTED gating
module fetch_ctrl #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic [PC_W-1:0]  off_sext;
    logic [CNT_W-1:0] cnt_inc;

    assign off_sext = {{(PC_W-OFF_W){bus.branch_off[OFF_W-1]}}, bus.branch_off};
    // Retired count saturates instead of wrapping so long runs still read as "at least".
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = bus.start_addr;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                    cnt_d   = cnt_inc;
                end else if (bus.stall) begin
                    pc_d  = pc_q;
                end else if (bus.branch_en) begin
                    pc_d  = bus.branch_abs ? bus.jump_target : pc_q + off_sext;
                    cnt_d = cnt_inc;
                end else begin
                    pc_d  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_ctrl_if #(.PC_W(16), .OFF_W(8), .CNT_W(16)) bus ();

    fetch_ctrl #(.PC_W(16), .OFF_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [15:0] pc, input logic run,
                                input logic dn, input logic [15:0] cnt);
        check_eq({tag, ".pc"}, 32'(bus.pc), 32'(pc));
        check_eq({tag, ".running"}, 32'(bus.running), 32'(run));
        check_eq({tag, ".done"}, 32'(bus.done), 32'(dn));
        check_eq({tag, ".count"}, 32'(bus.instr_count), 32'(cnt));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.start_addr   = '0;
        bus.stall        = 1'b0;
        bus.halt_req     = 1'b0;
        bus.branch_en    = 1'b0;
        bus.branch_abs   = 1'b0;
        bus.branch_off   = '0;
        bus.jump_target  = '0;
        step();
        step();
        check_status("reset", 16'h0000, 1'b0, 1'b0, 16'd0);

        // Sequential run to HALT at pc=4
        reset = 1'b0;
        bus.start = 1'b1;
        bus.start_addr = 16'h0000;
        step();
        bus.start = 1'b0;
        check_status("seq_start", 16'h0000, 1'b1, 1'b0, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("seq_pc", 32'(bus.pc), i);
        end
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        check_status("seq_halt", 16'h0004, 1'b0, 1'b1, 16'd5);
        step();
        check_status("halt_level", 16'h0004, 1'b0, 1'b1, 16'd5);

        // Restart from HALTED
        bus.start = 1'b1;
        bus.start_addr = 16'h0020;
        step();
        bus.start = 1'b0;
        check_status("restart", 16'h0020, 1'b1, 1'b0, 16'd0);
        step();
        check_eq("run_pc", 32'(bus.pc), 32'h21);
        bus.start = 1'b1;
        bus.start_addr = 16'h0099;
        step();
        bus.start = 1'b0;
        check_status("start_ignored", 16'h0022, 1'b1, 1'b0, 16'd2);

        // Branches
        bus.branch_en = 1'b1;
        bus.branch_abs = 1'b1;
        bus.jump_target = 16'h0010;
        step();
        check_eq("jump_to_10", 32'(bus.pc), 32'h10);
        bus.branch_abs = 1'b0;
        bus.branch_off = 8'hFC;
        step();
        check_eq("rel_neg", 32'(bus.pc), 32'h0C);
        bus.branch_abs = 1'b1;
        bus.jump_target = 16'h1234;
        step();
        check_eq("jump_abs", 32'(bus.pc), 32'h1234);
        bus.branch_abs = 1'b0;
        bus.branch_off = 8'h7F;
        step();
        bus.branch_en = 1'b0;
        check_status("rel_pos", 16'h12B3, 1'b1, 1'b0, 16'd6);

        // Wrap-around
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        bus.start = 1'b1;
        bus.start_addr = 16'hFFFE;
        step();
        bus.start = 1'b0;
        check_eq("wrap_pc0", 32'(bus.pc), 32'hFFFE);
        step();
        check_eq("wrap_pc1", 32'(bus.pc), 32'hFFFF);
        step();
        check_eq("wrap_pc2", 32'(bus.pc), 32'h0000);
        step();
        step();
        check_eq("wrap_pc4", 32'(bus.pc), 32'h0002);
        bus.branch_en = 1'b1;
        bus.branch_abs = 1'b0;
        bus.branch_off = 8'hFC;
        step();
        check_status("wrap_rel", 16'hFFFE, 1'b1, 1'b0, 16'd5);

        // Stall priority
        bus.branch_abs = 1'b1;
        bus.jump_target = 16'h0005;
        step();
        check_eq("jump_to_5", 32'(bus.pc), 32'h5);
        bus.branch_abs = 1'b0;
        bus.branch_off = 8'h10;
        bus.stall = 1'b1;
        step();
        check_status("stall1", 16'h0005, 1'b1, 1'b0, 16'd6);
        step();
        check_status("stall2", 16'h0005, 1'b1, 1'b0, 16'd6);
        bus.stall = 1'b0;
        step();
        bus.branch_en = 1'b0;
        check_status("stall_release", 16'h0015, 1'b1, 1'b0, 16'd7);
        bus.stall = 1'b1;
        bus.halt_req = 1'b1;
        step();
        bus.stall = 1'b0;
        bus.halt_req = 1'b0;
        check_status("stall_halt", 16'h0015, 1'b0, 1'b1, 16'd8);

        // Counter saturation
        bus.start = 1'b1;
        bus.start_addr = 16'h0000;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        check_status("sat_run", 16'h0004, 1'b1, 1'b0, 16'hFFFF);
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        check_status("sat_halt", 16'h0004, 1'b0, 1'b1, 16'hFFFF);

        // Reset mid-run with simultaneous start
        bus.start = 1'b1;
        bus.start_addr = 16'h0040;
        step();
        bus.start = 1'b0;
        step();
        step();
        check_eq("pre_reset_pc", 32'(bus.pc), 32'h42);
        reset = 1'b1;
        bus.start = 1'b1;
        step();
        check_status("reset_mid", 16'h0000, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        bus.start = 1'b0;
        bus.halt_req = 1'b1;
        bus.branch_en = 1'b1;
        step();
        bus.halt_req = 1'b0;
        bus.branch_en = 1'b0;
        check_status("idle_ignore", 16'h0000, 1'b0, 1'b0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and fetch sequencer that sits directly upstream of the instruction ROM/decoder. It drives the 16-bit `pc` that the ROM decodes, and advances it sequentially, by relative branch, or by absolute jump. It stops on HALT and reports completion. A small state machine gates execution between program launches, and a retired-instruction counter supports test measurement.

## Interface
- `PC_W`, 16, program-counter width; matches the ROM address input.
- `OFF_W`, 8, width of the signed relative-branch offset.
- `CNT_W`, 16, width of the retired-instruction counter.

- `clk`  in  1  system clock; rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request. Sampled only in IDLE or HALTED.
- `start_addr`  in  PC_W  first instruction address, loaded on an accepted `start`.
- `stall`  in  1  holds `pc` for this cycle; the instruction is not retired.
- `halt_req`  in  1  current instruction is HALT, from the decoder opcode.
- `branch_en`  in  1  current instruction redirects flow: taken branch or jump.
- `branch_abs`  in  1  when 1, use `jump_target`; when 0, use `pc + sext(branch_off)`.
- `branch_off`  in  OFF_W  signed two's-complement offset.
- `jump_target`  in  PC_W  absolute target address.
- `pc`  out  PC_W  registered program counter driving the ROM.
- `running`  out  1  high while in RUN.
- `done`  out  1  high while in HALTED.
- `instr_count`  out  CNT_W  instructions retired since the last accepted `start`.

## Operation
- States: IDLE, RUN, HALTED.
- Reset values: state=IDLE, `pc`=0, `running`=0, `done`=0, `instr_count`=0.
- IDLE:
  - `start`=1 -> `pc`<=`start_addr`, `instr_count`<=0, go to RUN.
  - All other inputs are ignored.
- RUN: all control inputs are evaluated once per cycle, with priority halt_req > stall > branch_en > sequential.
  - `halt_req`=1 (even if `stall`=1):
    - go to HALTED and hold `pc` at the HALT address.
    - `instr_count` += 1, because HALT counts as retired.
  - `stall`=1 -> `pc` and `instr_count` hold; `branch_en` is ignored this cycle.
  - `branch_en`=1:
    - `branch_abs`=1 -> `pc`<=`jump_target`.
    - `branch_abs`=0 -> `pc`<=(`pc` + sign-extend(`branch_off`)) mod 2^PC_W.
    - `instr_count` += 1.
  - Otherwise -> `pc`<=(`pc`+1) mod 2^PC_W, and `instr_count` += 1.
  - `start` is ignored in RUN.
- HALTED:
  - `pc` and `instr_count` are frozen.
  - `start`=1 -> same reload as in IDLE, then RUN; `done` drops.
- Arithmetic:
  - All `pc` updates are modulo 2^PC_W: 0xFFFF+1 -> 0x0000, and 0x0002 + (-4) -> 0xFFFE.
  - `branch_off` is sign-extended to PC_W before the add.
  - `instr_count` saturates at 2^CNT_W-1; it does not wrap.
- `reset` has priority over everything. Asserting it mid-RUN returns to IDLE with all reset values on the next edge.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- The ROM/decoder responds combinationally to `pc`. `halt_req` and the `branch_*` inputs for the instruction at `pc` are therefore valid in the same cycle and are sampled at the next edge.
- Fetch latency is 1 cycle:
  - A non-stalled, non-branching instruction at `pc`=N yields `pc`=N+1 one edge later.
  - A taken branch lands on its target one edge later, with no delay slot and no bubble.
- `start` accepted at edge k:
  - `pc`=`start_addr` and `running`=1 are visible after edge k.
  - The first instruction is decoded in cycle k+1.
- `halt_req` sampled at edge k:
  - `running`=0 and `done`=1 after edge k; `pc` is unchanged from cycle k.
- `done` is a level, not a pulse. It stays high until a new `start` or `reset`.
- `start` and `reset` in the same cycle -> `reset` wins.

## Test plan
- Sequential run:
  - Stimulus: reset, then `start`=1 with `start_addr`=0. Hold `halt_req`=0 for 4 cycles, then `halt_req`=1 at `pc`=4.
  - Required: `pc` steps 0,1,2,3,4 then holds 4; `done`=1; `running`=0; `instr_count`=5.
- Branches:
  - Stimulus 1: at `pc`=0x0010, `branch_en`=1, `branch_abs`=0, `branch_off`=0xFC.
  - Required 1: `pc`=0x000C.
  - Stimulus 2: then `branch_abs`=1, `jump_target`=0x1234.
  - Required 2: `pc`=0x1234.
  - Stimulus 3: then `branch_off`=0x7F with `branch_abs`=0.
  - Required 3: `pc`=0x12B3.
- Wrap-around:
  - Stimulus 1: `start_addr`=0xFFFE, no branches, 2 cycles.
  - Required 1: `pc` = 0xFFFE, 0xFFFF, 0x0000.
  - Stimulus 2: relative branch at `pc`=0x0002 with offset 0xFC.
  - Required 2: `pc`=0xFFFE.
- Stall priority:
  - Stimulus 1: at `pc`=5, `stall`=1 and `branch_en`=1 for 2 cycles.
  - Required 1: `pc` stays 5; `instr_count` unchanged.
  - Stimulus 2: release `stall`, keep the branch asserted.
  - Required 2: `pc` takes the branch target.
  - Stimulus 3: `stall`=1 together with `halt_req`=1.
  - Required 3: enters HALTED.
- Start handling:
  - Stimulus: `start` pulsed mid-RUN.
  - Required: ignored; `pc` keeps advancing.
  - Stimulus: `start` in HALTED with `start_addr`=0x0020.
  - Required: `pc`=0x0020, `done`=0, `running`=1, `instr_count`=0.
- Reset mid-run:
  - Stimulus: `reset`=1 at `pc`=0x0042 during RUN, with `start`=1 in the same cycle.
  - Required: next edge gives `pc`=0, IDLE, all outputs at reset values.
